// File: rtl/bubble_sort_engine.sv
// In-place bubble sort over a small register-file store: one adjacent pair per cycle, early exit on a swap-free pass.
// Optional macro BUBBLE_SORT_DESCENDING_EN selects descending order (default build sorts ascending, unsigned).
module bubble_sort_engine #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             write,
    input  logic [WIDTH-1:0] writedata,
    input  logic             start,
    input  logic [AW-1:0]    readaddr,
    output logic [WIDTH-1:0] readdata,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [AW-1:0] L_INIT = AW'(DEPTH - 2);
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE    = AW'(1);
    localparam logic [AW-1:0] ZERO   = AW'(0);

    // True when the pair (a, b) must be exchanged; equal values never swap.
    function automatic logic out_of_order(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef BUBBLE_SORT_DESCENDING_EN
        return (a < b);
`else
        return (a > b);
`endif
    endfunction

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    j_r;
    logic [AW-1:0]    lim_r;
    logic             swapped_r;
    logic             busy_r;
    logic             done_r;
    state_t           state_r;
    state_t           next_state_s;

    logic             accept_s;
    logic             wr_en_s;
    logic             start_en_s;
    logic [AW-1:0]    j_next_s;
    logic [WIDTH-1:0] elem_a_s;
    logic [WIDTH-1:0] elem_b_s;
    logic             swap_s;
    logic             pass_end_s;
    logic             finish_s;

    // Command qualification and compare-slot decode for the current cycle.
    always_comb begin
        accept_s   = (state_r == IDLE) || (state_r == DONE);
        wr_en_s    = accept_s && write && !clr;
        start_en_s = accept_s && start && !clr;
        j_next_s   = j_r + ONE;
        elem_a_s   = mem_r[j_r];
        elem_b_s   = mem_r[j_next_s];
        swap_s     = (state_r == COMPARE) && out_of_order(elem_a_s, elem_b_s);
        pass_end_s = (state_r == COMPARE) && (j_r == lim_r);
        finish_s   = pass_end_s && (!(swapped_r || swap_s) || (lim_r == ZERO));
    end

    // Next-state logic; clr overrides every other command.
    always_comb begin
        next_state_s = state_r;
        if (clr) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_en_s) next_state_s = COMPARE;
                    else            next_state_s = IDLE;
                end
                COMPARE: begin
                    if (finish_s) next_state_s = DONE;
                    else          next_state_s = COMPARE;
                end
                DONE: begin
                    if (start_en_s)   next_state_s = COMPARE;
                    else if (wr_en_s) next_state_s = IDLE;
                    else              next_state_s = DONE;
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == COMPARE);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Element store, load pointer and pass bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
            wr_ptr_r  <= ZERO;
            j_r       <= ZERO;
            lim_r     <= L_INIT;
            swapped_r <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
            wr_ptr_r  <= ZERO;
            j_r       <= ZERO;
            lim_r     <= L_INIT;
            swapped_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= writedata;
                wr_ptr_r        <= (wr_ptr_r == LAST) ? ZERO : (wr_ptr_r + ONE);
            end
            if (start_en_s) begin
                j_r       <= ZERO;
                lim_r     <= L_INIT;
                swapped_r <= 1'b0;
            end else if (state_r == COMPARE) begin
                if (swap_s) begin
                    mem_r[j_r]      <= elem_b_s;
                    mem_r[j_next_s] <= elem_a_s;
                end
                if (pass_end_s) begin
                    j_r       <= ZERO;
                    swapped_r <= 1'b0;
                    // The limit only shrinks when another pass follows.
                    if (!finish_s) lim_r <= lim_r - ONE;
                end else begin
                    j_r       <= j_next_s;
                    swapped_r <= swapped_r | swap_s;
                end
            end
        end
    end

    assign readdata = mem_r[readaddr];
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Scoreboard bench for bubble_sort_engine (WIDTH=4, DEPTH=4): directed loads, sorts, aborts and clears.
module tb_bubble_sort_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       write = 1'b0;
    logic [3:0] writedata = 4'd0;
    logic       start = 1'b0;
    logic [1:0] readaddr = 2'd0;
    logic [3:0] readdata;
    logic       busy;
    logic       done;

    logic       rd_req = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] data;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    string   name_q[$];
    int      lat_q[$];

    bubble_sort_engine #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .clr(clr), .write(write), .writedata(writedata),
        .start(start), .readaddr(readaddr), .readdata(readdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Monitor: busy-cycle latency on each rising done, and read responses on each read strobe.
    int   busy_cnt = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done && !done_prev) begin
                vectors++;
                if (lat_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done: got done after %0d busy cycles, required no sort", busy_cnt);
                end else begin
                    int e;
                    e = lat_q.pop_front();
                    if (busy_cnt != e) begin
                        miscompares++;
                        $display("FAIL latency: got %0d busy cycles, required %0d", busy_cnt, e);
                    end
                end
                busy_cnt = 0;
            end
            done_prev = done;
        end
        if (rd_req) begin
            rd_exp_t e;
            string   n;
            vectors++;
            e = rd_q.pop_front();
            n = name_q.pop_front();
            if ({busy, done, readdata} !== e) begin
                miscompares++;
                $display("FAIL %s: got busy=%0b done=%0b data=%0d, required busy=%0b done=%0b data=%0d",
                         n, busy, done, readdata, e.busy, e.done, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] v);
        write = 1'b1;
        writedata = v;
        tick();
        write = 1'b0;
    endtask

    task automatic load4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        do_write(a);
        do_write(b);
        do_write(c);
        do_write(d);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic do_start(input int lat, input bit expect_done);
        if (expect_done) lat_q.push_back(lat);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got done=0 after %0d cycles, required done=1", tag, n);
        end
        tick();
    endtask

    task automatic rd(input logic [1:0] a, input logic [3:0] d, input logic eb, input logic ed, input string tag);
        rd_exp_t e;
        e.busy = eb;
        e.done = ed;
        e.data = d;
        rd_q.push_back(e);
        name_q.push_back($sformatf("%s[%0d]", tag, a));
        readaddr = a;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic rd4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d,
                       input logic eb, input logic ed, input string tag);
        rd(2'd0, a, eb, ed, tag);
        rd(2'd1, b, eb, ed, tag);
        rd(2'd2, c, eb, ed, tag);
        rd(2'd3, d, eb, ed, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        rd4(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "in_reset");
        reset = 1'b0;
        tick();

        // Unsorted input needing every pass.
        load4(4'd9, 4'd3, 4'd7, 4'd1);
`ifdef BUBBLE_SORT_DESCENDING_EN
        do_start(5, 1'b1);
        wait_done("sort_9371");
        rd4(4'd9, 4'd7, 4'd3, 4'd1, 1'b0, 1'b1, "sort_9371");
`else
        do_start(6, 1'b1);
        wait_done("sort_9371");
        rd4(4'd1, 4'd3, 4'd7, 4'd9, 1'b0, 1'b1, "sort_9371");
`endif

        // Already-ordered input; load from DONE returns to IDLE.
        load4(4'd1, 4'd2, 4'd3, 4'd4);
        rd(2'd0, 4'd1, 1'b0, 1'b0, "idle_after_load");
`ifdef BUBBLE_SORT_DESCENDING_EN
        do_start(6, 1'b1);
        wait_done("sort_1234");
        rd4(4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 1'b1, "sort_1234");
`else
        do_start(3, 1'b1);
        wait_done("sort_1234");
        rd4(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, "sort_1234");
`endif

        // Duplicates, a write ignored while busy, then the pointer must still be 0.
        load4(4'd5, 4'd5, 4'd2, 4'd5);
`ifdef BUBBLE_SORT_DESCENDING_EN
        do_start(5, 1'b1);
        do_write(4'd8);
        wait_done("sort_5525");
        rd4(4'd5, 4'd5, 4'd5, 4'd2, 1'b0, 1'b1, "sort_5525");
        do_write(4'd10);
        rd4(4'd10, 4'd5, 4'd5, 4'd2, 1'b0, 1'b0, "wr_ptr_zero");
`else
        do_start(6, 1'b1);
        do_write(4'd8);
        wait_done("sort_5525");
        rd4(4'd2, 4'd5, 4'd5, 4'd5, 1'b0, 1'b1, "sort_5525");
        do_write(4'd10);
        rd4(4'd10, 4'd5, 4'd5, 4'd5, 1'b0, 1'b0, "wr_ptr_zero");
`endif

        // Six loads wrap the pointer over the oldest two slots.
        do_clr();
        for (int v = 1; v <= 6; v++) do_write(4'(v));
        rd4(4'd5, 4'd6, 4'd3, 4'd4, 1'b0, 1'b0, "wrap_load");
`ifdef BUBBLE_SORT_DESCENDING_EN
        do_start(5, 1'b1);
        wait_done("sort_wrap");
        rd4(4'd6, 4'd5, 4'd4, 4'd3, 1'b0, 1'b1, "sort_wrap");
`else
        do_start(6, 1'b1);
        wait_done("sort_wrap");
        rd4(4'd3, 4'd4, 4'd5, 4'd6, 1'b0, 1'b1, "sort_wrap");
`endif

        // Reset in the second busy cycle aborts the sort and zeroes the store.
        do_clr();
        load4(4'd9, 4'd3, 4'd7, 4'd1);
        do_start(0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd4(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "reset_abort");
        repeat (8) tick();
        rd(2'd3, 4'd0, 1'b0, 1'b0, "reset_no_resume");

        // clr wins over a simultaneous start.
        do_write(4'd7);
        do_write(4'd2);
        clr = 1'b1;
        start = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b0;
        repeat (8) tick();
        rd4(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "clr_start");

        repeat (2) tick();
        vectors++;
        if (lat_q.size() != 0 || rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d latencies and %0d reads pending, required 0 and 0",
                     lat_q.size(), rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bubble_sort_engine.md
BUBBLE_SORT_ENGINE -- requirements
Module: bubble_sort_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the bit width of each element.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of elements; legal range is 2..64; AW = $clog2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of the element store and the load pointer; it aborts any sort.
REQ-006 The block SHALL have port write, input, 1 bit: loads writedata at the load pointer; honoured only in IDLE or DONE.
REQ-007 The block SHALL have port writedata, input, WIDTH bits: the element value to load.
REQ-008 The block SHALL have port start, input, 1 bit: begins a sort; honoured only in IDLE or DONE.
REQ-009 The block SHALL have port readaddr, input, AW bits: the element index to read.
REQ-010 The block SHALL have port readdata, output, WIDTH bits: combinational mem[readaddr]; it is valid in every state.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in COMPARE.
REQ-012 The block SHALL have port done, output, 1 bit: high while in DONE.

Function
REQ-013 The block SHALL implement the states IDLE, COMPARE and DONE.
REQ-014 A write SHALL store writedata at mem[wr_ptr] and then advance wr_ptr, wrapping from DEPTH-1 to 0; a load beyond DEPTH writes overwrite the oldest slots.
REQ-015 A write in DONE SHALL perform the store and move the block to IDLE.
REQ-016 A start in IDLE or DONE SHALL move the block to COMPARE with j=0, pass limit L=DEPTH-2 and the swapped flag cleared.
REQ-017 When write and start occur in the same cycle, the write SHALL be applied and the sort SHALL include the written value.
REQ-018 Each COMPARE cycle SHALL process exactly one adjacent pair (mem[j], mem[j+1]).
REQ-019 In a COMPARE cycle, if the pair is out of order, the two elements SHALL be exchanged on the same edge and the swapped flag SHALL be set.
REQ-020 Ordering SHALL be ascending and unsigned: the pair is out of order when mem[j] > mem[j+1]; equal values are never swapped, so the sort is stable.
REQ-021 At the end of a pass (j==L), the block SHALL go to DONE if no swap occurred in that pass including the current cycle, or if L==0.
REQ-022 Otherwise, at the end of a pass, the block SHALL set L=L-1, j=0, clear the swapped flag and remain in COMPARE.
REQ-023 Worst-case sort latency SHALL be DEPTH*(DEPTH-1)/2 cycles of busy; an already-sorted input SHALL take DEPTH-1 cycles.
REQ-024 A write or start arriving during COMPARE SHALL be ignored, with no effect on the store or on wr_ptr.
REQ-025 DONE SHALL hold until a write or start is received; the store SHALL remain stable while in DONE.
REQ-026 A clr SHALL zero all elements and wr_ptr and move the block to IDLE; clr SHALL have priority over write and start in the same cycle.
REQ-027 busy and done SHALL never be high in the same cycle.

Reset
REQ-028 While reset is high, the block SHALL be in IDLE, all mem=0, wr_ptr=0, j=0, L=DEPTH-2, swapped=0, busy=0, done=0 and readdata=0.
REQ-029 Reset asserted mid-sort SHALL abort the sort immediately; sorting SHALL resume only on a new start after reset is released.

Configuration
REQ-030 With BUBBLE_SORT_DESCENDING_EN defined, the ordering SHALL be descending: a pair is swapped when mem[j] < mem[j+1]; all timing is unchanged.
REQ-031 Without BUBBLE_SORT_DESCENDING_EN, the ordering SHALL be ascending per REQ-020.

Verification (WIDTH=4, DEPTH=4, ascending unless stated)
REQ-032 The bench SHALL cover: write 9,3,7,1, then start -> busy high for exactly 6 cycles, then done=1 and reads 0..3 return 1,3,7,9.
REQ-033 The bench SHALL cover: write 1,2,3,4, then start -> busy for 3 cycles (early exit), then done and the data is unchanged.
REQ-034 The bench SHALL cover: write 5,5,2,5, then start -> result 2,5,5,5; a write of 8 during busy has no effect; wr_ptr stays at 0.
REQ-035 The bench SHALL cover: write 6 values 1..6 -> mem holds 5,6,3,4 (wrap-around); start -> 3,4,5,6.
REQ-036 The bench SHALL cover: reset pulsed in the 2nd busy cycle -> all reads return 0, busy=0, done=0; clr together with start in IDLE -> no sort and the store reads 0.
REQ-037 The bench SHALL cover: with BUBBLE_SORT_DESCENDING_EN defined, write 9,3,7,1, then start -> result 9,7,3,1 after 5 busy cycles (early exit after the 2nd pass, which has no swap).
